issueq_int: RTL

// Integer issue queue: receiving end of the dispatch->equeueint handshake.

---
 rtl/issueq_int_if.sv | 52 +++++
 rtl/issueq_int.sv | 131 +++++++++++++
 2 files changed

// File: rtl/issueq_int_if.sv
// Dispatch -> integer issue queue -> integer unit bundle.
// Carries the dispatch write handshake (equeueint_*/equeue_*), the CDB
// broadcast snooped for operand wakeup, and the issue handshake toward the
// integer execution unit (issueint_*).
//   slave  : the issue queue's view (accepts dispatch, snoops CDB, presents ops)
//   master : the environment's view (dispatch, CDB and integer unit side)
interface issueq_int_if #(
  parameter int W_TAG  = 6,
  parameter int W_DATA = 32
);
  logic              equeueint_en;
  logic              equeueint_ready;
  logic [3:0]        equeueint_opcode;
  logic [15:0]       equeue_imm;
  logic [W_TAG-1:0]  equeue_rdtag;
  logic [W_TAG-1:0]  equeue_rstag;
  logic [W_TAG-1:0]  equeue_rttag;
  logic [W_DATA-1:0] equeue_rsdata;
  logic [W_DATA-1:0] equeue_rtdata;
  logic              equeue_rsvalid;
  logic              equeue_rtvalid;

  logic              cdb_valid;
  logic [W_TAG-1:0]  cdb_tag;
  logic [W_DATA-1:0] cdb_data;

  logic              issueint_ready;
  logic              issueint_valid;
  logic [3:0]        issueint_opcode;
  logic [15:0]       issueint_imm;
  logic [W_TAG-1:0]  issueint_rdtag;
  logic [W_DATA-1:0] issueint_rsdata;
  logic [W_DATA-1:0] issueint_rtdata;

  modport slave (
    input  equeueint_en, equeueint_opcode, equeue_imm, equeue_rdtag,
           equeue_rstag, equeue_rttag, equeue_rsdata, equeue_rtdata,
           equeue_rsvalid, equeue_rtvalid,
           cdb_valid, cdb_tag, cdb_data, issueint_ready,
    output equeueint_ready, issueint_valid, issueint_opcode, issueint_imm,
           issueint_rdtag, issueint_rsdata, issueint_rtdata
  );

  modport master (
    output equeueint_en, equeueint_opcode, equeue_imm, equeue_rdtag,
           equeue_rstag, equeue_rttag, equeue_rsdata, equeue_rtdata,
           equeue_rsvalid, equeue_rtvalid,
           cdb_valid, cdb_tag, cdb_data, issueint_ready,
    input  equeueint_ready, issueint_valid, issueint_opcode, issueint_imm,
           issueint_rdtag, issueint_rsdata, issueint_rtdata
  );
endinterface

// File: rtl/issueq_int.sv
// Integer issue queue.
// Buffers up to DEPTH decoded integer ops with operand tags/data, wakes
// pending operands from the CDB, and presents the oldest fully-ready op to
// the integer execution unit. Shifting organisation: slot 0 is the oldest.
// Ports:
//   clk      clock, all state on rising edge
//   reset_n  asynchronous active-low reset
//   bus      issueq_int_if.slave: dispatch write, CDB snoop, issue handshake
module issueq_int #(
  parameter int DEPTH  = 4,
  parameter int W_TAG  = 6,
  parameter int W_DATA = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  issueq_int_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic              busy;
    logic [3:0]        opcode;
    logic [15:0]       imm;
    logic [W_TAG-1:0]  rdtag;
    logic [W_TAG-1:0]  rstag;
    logic [W_TAG-1:0]  rttag;
    logic [W_DATA-1:0] rsdata;
    logic [W_DATA-1:0] rtdata;
    logic              rsvalid;
    logic              rtvalid;
  } entry_t;

  entry_t          q     [DEPTH];
  entry_t          q_nxt [DEPTH];
  entry_t          woke  [DEPTH+1];  // extra empty slot feeds the top on a shift
  entry_t          new_ent;
  entry_t          sel_ent;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [CW-1:0]   wr_slot;
  logic [IW-1:0]   sel_idx;
  logic            sel_found;
  logic            issue_fire;
  logic            wr_fire;

  assign bus.equeueint_ready = (count != CW'(DEPTH));

  // Oldest entry with both operands present.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!sel_found && q[i].busy && q[i].rsvalid && q[i].rtvalid) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
    sel_ent = sel_found ? q[sel_idx] : '0;
  end

  assign bus.issueint_valid  = sel_found;
  assign bus.issueint_opcode = sel_ent.opcode;
  assign bus.issueint_imm    = sel_ent.imm;
  assign bus.issueint_rdtag  = sel_ent.rdtag;
  assign bus.issueint_rsdata = sel_ent.rsdata;
  assign bus.issueint_rtdata = sel_ent.rtdata;

  assign issue_fire = sel_found & bus.issueint_ready;
  assign wr_fire    = bus.equeueint_en & bus.equeueint_ready;
  // New entry lands behind the surviving entries after compaction.
  assign wr_slot    = count - CW'(issue_fire);
  assign count_nxt  = count + CW'(wr_fire) - CW'(issue_fire);

  // Incoming entry, with same-cycle CDB capture of a missing operand.
  always_comb begin
    new_ent         = '0;
    new_ent.busy    = 1'b1;
    new_ent.opcode  = bus.equeueint_opcode;
    new_ent.imm     = bus.equeue_imm;
    new_ent.rdtag   = bus.equeue_rdtag;
    new_ent.rstag   = bus.equeue_rstag;
    new_ent.rttag   = bus.equeue_rttag;
    new_ent.rsdata  = bus.equeue_rsdata;
    new_ent.rtdata  = bus.equeue_rtdata;
    new_ent.rsvalid = bus.equeue_rsvalid;
    new_ent.rtvalid = bus.equeue_rtvalid;
    if (bus.cdb_valid && !bus.equeue_rsvalid && bus.cdb_tag == bus.equeue_rstag) begin
      new_ent.rsvalid = 1'b1;
      new_ent.rsdata  = bus.cdb_data;
    end
    if (bus.cdb_valid && !bus.equeue_rtvalid && bus.cdb_tag == bus.equeue_rttag) begin
      new_ent.rtvalid = 1'b1;
      new_ent.rtdata  = bus.cdb_data;
    end
  end

  // Wakeup is applied before the shift so captured data follows its entry.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woke[i] = q[i];
      if (q[i].busy && !q[i].rsvalid && bus.cdb_valid && bus.cdb_tag == q[i].rstag) begin
        woke[i].rsvalid = 1'b1;
        woke[i].rsdata  = bus.cdb_data;
      end
      if (q[i].busy && !q[i].rtvalid && bus.cdb_valid && bus.cdb_tag == q[i].rttag) begin
        woke[i].rtvalid = 1'b1;
        woke[i].rtdata  = bus.cdb_data;
      end
    end
    woke[DEPTH] = '0;
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (issue_fire && i >= 32'(sel_idx)) q_nxt[i] = woke[i+1];
      else                                 q_nxt[i] = woke[i];
      if (wr_fire && 32'(wr_slot) == i)    q_nxt[i] = new_ent;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      count <= count_nxt;
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
    end
  end
endmodule
